if_fetch: RTL
=============

# if_fetch

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the IF/ID pipeline register. Owns the PC, issues requests to a variable-latency instruction memory, and presents `pc_four_1`/`instr_1` plus a write enable and a flush to IF/ID. Handles load-use stalls from the hazard unit and taken-branch/jump redirects from ID, including redirects that arrive while a fetch is still outstanding.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pcwrite`  in  1  from the hazard unit; 0 = stall fetch.
- `redirect`  in  1  from ID; a branch is taken or a jump is being executed.
- `redirect_pc`  in  32  target address for `redirect`.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address, word aligned.
- `imem_ready`  in  1  memory has data for the current request this cycle; may be combinational.
- `imem_rdata`  in  32  instruction word, valid when `imem_ready` is 1.
- `pc_four_1`  out  32  PC+4 of the presented instruction.
- `instr_1`  out  32  presented instruction.
- `ifwrite`  out  1  write enable for IF/ID.
- `if_flush`  out  1  flush for IF/ID.

## Operation
- State machine states:
  - FETCH: request outstanding at `pc`.
  - HOLD: instruction captured while the pipeline is stalled.
  - DISCARD: a redirect arrived while a request was outstanding.
- `imem_addr = pc`.
- `imem_req` is 1 in FETCH and DISCARD and 0 in HOLD. Once `imem_req` is raised, address and request stay stable until `imem_ready` is 1.
- `instr_valid` is internal:
  - FETCH: equals `imem_ready`; the block presents `imem_rdata` and `pc+4`.
  - HOLD: 1; the block presents the hold buffer.
  - DISCARD: 0.
- When `instr_valid` is 0, `instr_1 = 0` (NOP) and `pc_four_1 = 0`.
- `ifwrite = instr_valid & pcwrite & ~redirect`.
- `if_flush = redirect`.
- Input priority: `rst` > `redirect` > `pcwrite`.
- FETCH transitions:
  - `redirect` and `imem_ready`: `pc <= redirect_pc`; stay in FETCH.
  - `redirect` and no ready: latch `redirect_pc` into the target register; go to DISCARD.
  - `imem_ready` and `pcwrite`: `pc <= pc+4`; stay in FETCH.
  - `imem_ready` and no `pcwrite`: capture `imem_rdata` and `pc+4` into the hold buffer; go to HOLD.
  - No ready: stay in FETCH.
- HOLD transitions:
  - `redirect`: `pc <= redirect_pc`; go to FETCH.
  - `pcwrite`: `pc <= pc+4`; go to FETCH.
  - Otherwise: stay in HOLD.
- DISCARD transitions:
  - A new `redirect` overwrites the target register. The latest redirect wins.
  - On `imem_ready`, the data is dropped; `pc <=` target register (or `redirect_pc` if `redirect` is 1 the same cycle); go to FETCH.
- Arithmetic: `pc+4` is modulo 2^32, so `32'hFFFF_FFFC` wraps to 0. `redirect_pc[1:0]` is forced to `2'b00` on load.

## Timing
- Values during and immediately after reset:
  - `pc = RESET_PC`, state FETCH, `imem_req = 1`.
  - Outputs `0 / 0 / 0 / 0`.
  - Hold buffer and target register are 0.
- Reset asserted mid-request abandons the request. The memory must tolerate this.
- Latency and throughput:
  - With zero-wait memory (`imem_ready` tied to 1), throughput is one instruction per cycle.
  - An instruction is presented in the same cycle its data returns.
  - N wait cycles give N bubbles: `ifwrite = 0`, no flush.
- Stall: the HOLD cycle count equals the number of `pcwrite = 0` cycles after capture. No refetch is issued.
- Redirect penalty:
  - One flushed slot (the fall-through instruction) when the redirect hits in FETCH or HOLD.
  - When the redirect hits in DISCARD, the penalty is the remaining memory latency plus the target fetch latency.
- IF/ID captures on the falling edge. All outputs are functions of rising-edge state plus inputs, and must settle within half a cycle.

## Structure
- Shared package `mips_pkg`:
  - state encoding (FETCH, HOLD, DISCARD);
  - `NOP_INSTR = 32'h0`;
  - default reset PC.
- Sub-module `if_hold_buf`: 64-bit register holding `{pc_four, instr}`, with load enable and asynchronous clear.
- Everything else stays in `if_fetch`: FSM, PC register, target register, output mux.

## Test plan
- Reset, zero-wait memory, `pcwrite = 1` for 4 cycles → `imem_addr` 0, 4, 8, C. `ifwrite = 1` each cycle. `pc_four_1` 4, 8, C, 10.
- Data returns at PC=8 with `pcwrite = 0` for 3 cycles → HOLD for 3 cycles, `imem_req = 0`, `instr_1` stable, `ifwrite = 0`. Next fetch is at C.
- At PC=10, `redirect = 1` with `redirect_pc = 32'h40` and zero-wait memory → `if_flush = 1` and `ifwrite = 0` that cycle. Next `imem_addr = 40`.
- `imem_ready` held low 3 cycles at PC=20; `redirect` to `32'h80` in cycle 1, then to `32'h90` in cycle 2 → the returned data is dropped and never presented. Next address is 90.
- `RESET_PC = 32'hFFFF_FFFC`, zero-wait memory → addresses FFFFFFFC then 0. `pc_four_1 = 0` on the first instruction.
- `rst` pulsed while in HOLD and while in DISCARD → all outputs are 0 immediately, and `imem_addr = RESET_PC` on the first cycle after reset deasserts.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage types and constants
package mips_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/if_hold_buf.sv
// rtl/if_hold_buf.sv - {pc_four, instr} holding register for stalled fetches
module if_hold_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld,
  input  logic [63:0] d,
  output logic [63:0] q
);

  logic [63:0] data_q;
  logic [63:0] data_d;

  always_comb begin
    data_d = data_q;
    if (ld) data_d = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - MIPS instruction-fetch stage: PC, imem handshake, stall and redirect handling
module if_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcwrite,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_four_1,
  output logic [31:0] instr_1,
  output logic        ifwrite,
  output logic        if_flush
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tgt_q, tgt_d;
  logic         hold_ld;
  logic [63:0]  hold_q;
  logic [31:0]  pc_plus4;
  logic [31:0]  redir_al;
  logic         instr_valid;

  assign pc_plus4 = pc_q + 32'd4;
  assign redir_al = word_align(redirect_pc);

  if_hold_buf u_hold_buf (
    .clk (clk),
    .rst (rst),
    .ld  (hold_ld),
    .d   ({pc_plus4, imem_rdata}),
    .q   (hold_q)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    hold_ld = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (redirect) begin
          if (imem_ready) begin
            pc_d = redir_al;
          end else begin
            tgt_d   = redir_al;
            state_d = ST_DISCARD;
          end
        end else if (imem_ready) begin
          if (pcwrite) begin
            pc_d = pc_plus4;
          end else begin
            hold_ld = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // pc_q still addresses the held instruction, so pc+4 is the fall-through
        if (redirect) begin
          pc_d    = redir_al;
          state_d = ST_FETCH;
        end else if (pcwrite) begin
          pc_d    = pc_plus4;
          state_d = ST_FETCH;
        end
      end
      ST_DISCARD: begin
        if (imem_ready) begin
          pc_d    = redirect ? redir_al : tgt_q;
          state_d = ST_FETCH;
        end else if (redirect) begin
          tgt_d = redir_al;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    instr_valid = 1'b0;
    pc_four_1   = 32'h0;
    instr_1     = NOP_INSTR;
    case (state_q)
      ST_FETCH: instr_valid = imem_ready;
      ST_HOLD:  instr_valid = 1'b1;
      default:  instr_valid = 1'b0;
    endcase
    // outputs stay quiet while reset is held, even if memory answers
    if (rst) instr_valid = 1'b0;
    if (instr_valid) begin
      if (state_q == ST_HOLD) begin
        pc_four_1 = hold_q[63:32];
        instr_1   = hold_q[31:0];
      end else begin
        pc_four_1 = pc_plus4;
        instr_1   = imem_rdata;
      end
    end
  end

  assign imem_addr = pc_q;
  assign imem_req  = (state_q != ST_HOLD);
  assign ifwrite   = instr_valid & pcwrite & ~redirect;
  assign if_flush  = redirect & ~rst;

endmodule
